// File: rtl/membus_pkg.sv
// Shared definitions for the memory-bus top level and its arbiter:
// grant-state encoding, bus widths and a byte-lane helper.
package membus_pkg;

  typedef enum logic [1:0] {
    GS_NONE = 2'd0,
    GS_CPU  = 2'd1,
    GS_L1   = 2'd2,
    GS_L2   = 2'd3
  } grant_t;

  localparam int MEM_AW   = 18;
  localparam int MEM_DW   = 32;
  localparam int LAYER_AW = 16;
  localparam int CPU_DW   = 8;

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/membus_if.sv
// Memory-side bus between the arbiter (master) and the memory (slave).
interface membus_if;
  import membus_pkg::*;

  // mem_strobe is a one-cycle command with no back-pressure: the memory
  // always accepts it, and mem_rddata is valid in the following cycle.
  logic              mem_strobe;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wrdata;
  logic [3:0]        mem_bytesel;
  logic [MEM_DW-1:0] mem_rddata;

  modport master (
    output mem_strobe, mem_write, mem_addr, mem_wrdata, mem_bytesel,
    input  mem_rddata
  );

  modport slave (
    input  mem_strobe, mem_write, mem_addr, mem_wrdata, mem_bytesel,
    output mem_rddata
  );

endinterface

// File: rtl/membus_arbiter.sv
// Single-port memory arbiter: one CPU byte access path and two round-robin
// layer fetch ports, with a bounded CPU burst while a layer is waiting.
module membus_arbiter
  import membus_pkg::*;
#(
    parameter int CPU_MAX_CONSEC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req,
    input  logic                cpu_write,
    input  logic [MEM_AW-1:0]   cpu_addr,
    input  logic [CPU_DW-1:0]   cpu_wrdata,
    output logic                cpu_busy,
    output logic                cpu_ack,
    output logic [CPU_DW-1:0]   cpu_rddata,
    output logic                cpu_overrun,
    input  logic                l1_req,
    input  logic                l2_req,
    input  logic [LAYER_AW-1:0] l1_addr,
    input  logic [LAYER_AW-1:0] l2_addr,
    output logic                l1_ack,
    output logic                l2_ack,
    membus_if.master            bus,
    output grant_t              dbg_state
);

    localparam int CW = (CPU_MAX_CONSEC < 1) ? 1 : $clog2(CPU_MAX_CONSEC + 1);
    localparam logic [CW-1:0] CONSEC_MAX = CW'(CPU_MAX_CONSEC);

    grant_t            state;
    grant_t            grant;
    logic [CW-1:0]     cpu_consec;
    logic              rr_last_l1;
    logic [MEM_AW-1:0] hold_addr;
    logic              hold_write;
    logic [CPU_DW-1:0] hold_wrdata;
    logic [1:0]        fl_lane;
    logic              fl_write;
    logic [CPU_DW-1:0] rddata_q;
    logic [CPU_DW-1:0] lane_byte;
    logic              layer_req;
    logic              force_layer;
    logic              cpu_grant;
    logic              cpu_accept;

    function automatic grant_t rr_pick(input logic r1, input logic r2,
                                       input logic last_l1);
        if (r1 && r2) return last_l1 ? GS_L2 : GS_L1;
        else if (r1)  return GS_L1;
        else          return GS_L2;
    endfunction

    assign layer_req   = l1_req | l2_req;
    assign force_layer = layer_req && (cpu_consec >= CONSEC_MAX);
    assign cpu_grant   = (grant == GS_CPU);
    // A request landing in the CPU grant cycle refills the slot being freed.
    assign cpu_accept  = cpu_req && (!cpu_busy || cpu_grant);

    // Grant decision; held off while reset is asserted so mem_* stay at 0.
    always_comb begin
        grant = GS_NONE;
        if (!rst_n)
            grant = GS_NONE;
        else if (cpu_busy && !force_layer)
            grant = GS_CPU;
        else if (layer_req)
            grant = rr_pick(l1_req, l2_req, rr_last_l1);
    end

    always_comb begin
        bus.mem_strobe  = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wrdata  = '0;
        bus.mem_bytesel = 4'b0000;
        case (grant)
            GS_CPU: begin
                bus.mem_strobe  = 1'b1;
                bus.mem_write   = hold_write;
                bus.mem_addr    = hold_addr;
                bus.mem_wrdata  = {4{hold_wrdata}};
                bus.mem_bytesel = lane_onehot(hold_addr[1:0]);
            end
            GS_L1: begin
                bus.mem_strobe  = 1'b1;
                bus.mem_addr    = {l1_addr, 2'b00};
                bus.mem_bytesel = 4'b1111;
            end
            GS_L2: begin
                bus.mem_strobe  = 1'b1;
                bus.mem_addr    = {l2_addr, 2'b00};
                bus.mem_bytesel = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GS_NONE;
            rr_last_l1 <= 1'b0;
            cpu_consec <= '0;
        end else begin
            state <= grant;
            if (grant == GS_L1)
                rr_last_l1 <= 1'b1;
            else if (grant == GS_L2)
                rr_last_l1 <= 1'b0;
            if (cpu_grant) begin
                if (cpu_consec < CONSEC_MAX)
                    cpu_consec <= cpu_consec + CW'(1);
            end else begin
                cpu_consec <= '0;
            end
        end
    end

    // CPU holding slot plus the attributes of the access currently in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_busy    <= 1'b0;
            cpu_overrun <= 1'b0;
            hold_addr   <= '0;
            hold_write  <= 1'b0;
            hold_wrdata <= '0;
            fl_lane     <= 2'b00;
            fl_write    <= 1'b0;
        end else begin
            if (cpu_accept) begin
                cpu_busy    <= 1'b1;
                hold_addr   <= cpu_addr;
                hold_write  <= cpu_write;
                hold_wrdata <= cpu_wrdata;
            end else if (cpu_grant) begin
                cpu_busy <= 1'b0;
            end
            if (cpu_req && cpu_busy && !cpu_grant)
                cpu_overrun <= 1'b1;
            if (cpu_grant) begin
                fl_lane  <= hold_addr[1:0];
                fl_write <= hold_write;
            end
        end
    end

    assign lane_byte = bus.mem_rddata[{fl_lane, 3'b000} +: CPU_DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rddata_q <= '0;
        else if (state == GS_CPU && !fl_write)
            rddata_q <= lane_byte;
    end

    // Read data is forwarded during the ack cycle and held afterwards.
    assign cpu_rddata = (state == GS_CPU && !fl_write) ? lane_byte : rddata_q;
    assign cpu_ack    = (state == GS_CPU);
    assign l1_ack     = (state == GS_L1);
    assign l2_ack     = (state == GS_L2);
    assign dbg_state  = state;

endmodule
